// File: rtl/serial_subtractor.sv
// Bit-serial W-bit subtractor (diff = a - b, LSB first) with a gate-level full-subtractor cell.
// Optional signed overflow flag o_ovf is built when SUB_SIGNED_OVF_EN is defined.

module my_xor (
    input  logic i_a,
    input  logic i_b,
    output logic o_y
);
    assign o_y = i_a ^ i_b;
endmodule

module my_and (
    input  logic i_a,
    input  logic i_b,
    output logic o_y
);
    assign o_y = i_a & i_b;
endmodule

module my_or (
    input  logic i_a,
    input  logic i_b,
    output logic o_y
);
    assign o_y = i_a | i_b;
endmodule

module my_nor (
    input  logic i_a,
    input  logic i_b,
    output logic o_y
);
    assign o_y = ~(i_a | i_b);
endmodule

module full_sub_cell (
    input  logic i_x,
    input  logic i_y,
    input  logic i_bin,
    output logic o_d,
    output logic o_bout
);
    logic w_xy;
    logic w_nx;
    logic w_nx_y;
    logic w_nx_bin;
    logic w_y_bin;
    logic w_or0;

    my_xor u_xor0 (.i_a(i_x),  .i_b(i_y),   .o_y(w_xy));
    my_xor u_xor1 (.i_a(w_xy), .i_b(i_bin), .o_y(o_d));

    // NOR with both inputs tied acts as the inverter for ~x
    my_nor u_inv  (.i_a(i_x),  .i_b(i_x),   .o_y(w_nx));
    my_and u_and0 (.i_a(w_nx), .i_b(i_y),   .o_y(w_nx_y));
    my_and u_and1 (.i_a(w_nx), .i_b(i_bin), .o_y(w_nx_bin));
    my_and u_and2 (.i_a(i_y),  .i_b(i_bin), .o_y(w_y_bin));
    my_or  u_or0  (.i_a(w_nx_y), .i_b(w_nx_bin), .o_y(w_or0));
    my_or  u_or1  (.i_a(w_or0),  .i_b(w_y_bin),  .o_y(o_bout));
endmodule

module serial_subtractor #(
    parameter  int W  = 8,
    localparam int CW = $clog2(W + 1)
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         i_start,
    input  logic [W-1:0] i_a,
    input  logic [W-1:0] i_b,
    output logic         o_busy,
    output logic         o_done,
    output logic [W-1:0] o_diff,
    output logic         o_borrow_out
`ifdef SUB_SIGNED_OVF_EN
    ,
    output logic         o_ovf
`endif
);
    typedef enum logic {
        S_IDLE  = 1'b0,
        S_SHIFT = 1'b1
    } state_t;

    localparam logic [CW-1:0] LP_LAST = CW'(W - 1);

    state_t         r_state;
    logic [W-1:0]   r_sa;
    logic [W-1:0]   r_sb;
    logic [W-1:0]   r_acc;
    logic [CW-1:0]  r_cnt;
    logic           r_bin;
    logic           r_busy;
    logic           r_done;
    logic [W-1:0]   r_diff;
    logic           r_borrow;
`ifdef SUB_SIGNED_OVF_EN
    logic           r_a_msb;
    logic           r_b_msb;
    logic           r_ovf;
`endif

    logic           w_d;
    logic           w_bnext;
    logic [W-1:0]   w_acc_next;

    full_sub_cell u_cell (
        .i_x    (r_sa[0]),
        .i_y    (r_sb[0]),
        .i_bin  (r_bin),
        .o_d    (w_d),
        .o_bout (w_bnext)
    );

    // Shift-right-with-insert written this way so W=1 needs no special slice
    always_comb begin
        w_acc_next        = r_acc >> 1;
        w_acc_next[W-1]   = w_d;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= S_IDLE;
            r_sa     <= '0;
            r_sb     <= '0;
            r_acc    <= '0;
            r_cnt    <= '0;
            r_bin    <= 1'b0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
            r_diff   <= '0;
            r_borrow <= 1'b0;
`ifdef SUB_SIGNED_OVF_EN
            r_a_msb  <= 1'b0;
            r_b_msb  <= 1'b0;
            r_ovf    <= 1'b0;
`endif
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_done <= 1'b0;
                    if (i_start) begin
                        r_sa    <= i_a;
                        r_sb    <= i_b;
                        r_acc   <= '0;
                        r_bin   <= 1'b0;
                        r_cnt   <= '0;
                        r_busy  <= 1'b1;
                        r_state <= S_SHIFT;
`ifdef SUB_SIGNED_OVF_EN
                        r_a_msb <= i_a[W-1];
                        r_b_msb <= i_b[W-1];
`endif
                    end
                end
                S_SHIFT: begin
                    r_sa  <= r_sa >> 1;
                    r_sb  <= r_sb >> 1;
                    r_acc <= w_acc_next;
                    r_bin <= w_bnext;
                    r_cnt <= r_cnt + CW'(1);
                    if (r_cnt == LP_LAST) begin
                        r_diff   <= w_acc_next;
                        r_borrow <= w_bnext;
                        r_done   <= 1'b1;
                        r_busy   <= 1'b0;
                        r_state  <= S_IDLE;
`ifdef SUB_SIGNED_OVF_EN
                        // w_d is the result sign bit on this final edge
                        r_ovf    <= (r_a_msb ^ r_b_msb) & (r_a_msb ^ w_d);
`endif
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign o_busy       = r_busy;
    assign o_done       = r_done;
    assign o_diff       = r_diff;
    assign o_borrow_out = r_borrow;
`ifdef SUB_SIGNED_OVF_EN
    assign o_ovf        = r_ovf;
`endif

endmodule

// File: tb/tb_serial_subtractor.sv
// Scoreboard bench for serial_subtractor: W=8 and W=1 instances, directed vectors.
// Exercises the ovf path as well when SUB_SIGNED_OVF_EN is defined.

module tb_serial_subtractor;

    typedef struct {
        logic [7:0] diff;
        logic       borrow;
        logic       ovf;
        int         cyc;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst;
    logic       start8, start1;
    logic [7:0] a8, b8;
    logic [0:0] a1, b1;
    logic       busy8, done8, borrow8;
    logic [7:0] diff8;
    logic       busy1, done1, borrow1;
    logic [0:0] diff1;
    logic       ovf8, ovf1;

    exp_t       q8[$];
    exp_t       q1[$];
    int         cyc = 0;
    int         checks = 0;
    int         failures = 0;
    logic [7:0] last_diff8 = 8'h00;
    logic       prev_done8 = 1'b0;
    logic       prev_done1 = 1'b0;

    always #50 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    serial_subtractor #(.W(8)) u_dut8 (
        .clk          (clk),
        .rst          (rst),
        .i_start      (start8),
        .i_a          (a8),
        .i_b          (b8),
        .o_busy       (busy8),
        .o_done       (done8),
        .o_diff       (diff8),
        .o_borrow_out (borrow8)
`ifdef SUB_SIGNED_OVF_EN
        ,
        .o_ovf        (ovf8)
`endif
    );

    serial_subtractor #(.W(1)) u_dut1 (
        .clk          (clk),
        .rst          (rst),
        .i_start      (start1),
        .i_a          (a1),
        .i_b          (b1),
        .o_busy       (busy1),
        .o_done       (done1),
        .o_diff       (diff1),
        .o_borrow_out (borrow1)
`ifdef SUB_SIGNED_OVF_EN
        ,
        .o_ovf        (ovf1)
`endif
    );

`ifndef SUB_SIGNED_OVF_EN
    assign ovf8 = 1'b0;
    assign ovf1 = 1'b0;
`endif

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=0x%0h required=0x%0h", name, act, req);
        end
    endtask

    // Monitors: pop the scoreboard on every done pulse
    always @(negedge clk) begin
        if (!rst) begin
            if (prev_done8) chk("done8_one_cycle", {31'd0, done8}, 32'd0);
            if (done8) begin
                if (q8.size() == 0) begin
                    chk("done8_unexpected", 32'd1, 32'd0);
                end else begin
                    exp_t e;
                    e = q8.pop_front();
                    chk("w8_latency", cyc, e.cyc);
                    chk("w8_diff", {24'd0, diff8}, {24'd0, e.diff});
                    chk("w8_borrow", {31'd0, borrow8}, {31'd0, e.borrow});
                    chk("w8_busy_at_done", {31'd0, busy8}, 32'd0);
`ifdef SUB_SIGNED_OVF_EN
                    chk("w8_ovf", {31'd0, ovf8}, {31'd0, e.ovf});
`endif
                    last_diff8 = e.diff;
                end
            end
            if (prev_done1) chk("done1_one_cycle", {31'd0, done1}, 32'd0);
            if (done1) begin
                if (q1.size() == 0) begin
                    chk("done1_unexpected", 32'd1, 32'd0);
                end else begin
                    exp_t e;
                    e = q1.pop_front();
                    chk("w1_latency", cyc, e.cyc);
                    chk("w1_diff", {31'd0, diff1}, {31'd0, e.diff[0]});
                    chk("w1_borrow", {31'd0, borrow1}, {31'd0, e.borrow});
`ifdef SUB_SIGNED_OVF_EN
                    chk("w1_ovf", {31'd0, ovf1}, {31'd0, e.ovf});
`endif
                end
            end
        end
        prev_done8 = done8 & !rst;
        prev_done1 = done1 & !rst;
    end

    // Called at a negedge; the accepting edge is the next posedge
    task automatic issue8(input logic [7:0] a, input logic [7:0] b,
                          input logic [7:0] ed, input logic eb, input logic eo);
        exp_t e;
        e.diff = ed; e.borrow = eb; e.ovf = eo; e.cyc = cyc + 9;
        a8 = a; b8 = b; start8 = 1'b1;
        q8.push_back(e);
        @(negedge clk);
        start8 = 1'b0;
    endtask

    task automatic issue1(input logic a, input logic b,
                          input logic ed, input logic eb, input logic eo);
        exp_t e;
        e.diff = {7'd0, ed}; e.borrow = eb; e.ovf = eo; e.cyc = cyc + 2;
        a1 = a; b1 = b; start1 = 1'b1;
        q1.push_back(e);
        @(negedge clk);
        start1 = 1'b0;
    endtask

    task automatic busy_window8(input string name);
        for (int i = 0; i < 8; i++) begin
            chk({name, "_busy"}, {31'd0, busy8}, 32'd1);
            chk({name, "_held"}, {24'd0, diff8}, {24'd0, last_diff8});
            @(negedge clk);
        end
    endtask

    task automatic wait_done8(input string name);
        int n = 0;
        while (!done8 && n < 30) begin
            @(negedge clk);
            n++;
        end
        chk({name, "_no_timeout"}, {31'd0, done8}, 32'd1);
    endtask

    task automatic wait_done1(input string name);
        int n = 0;
        while (!done1 && n < 10) begin
            @(negedge clk);
            n++;
        end
        chk({name, "_no_timeout"}, {31'd0, done1}, 32'd1);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) @(negedge clk);
    endtask

    initial begin
        #(100 * 5000);
        $display("FAIL watchdog expired actual=running required=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; start8 = 1'b0; start1 = 1'b0;
        a8 = 8'h00; b8 = 8'h00; a1 = 1'b0; b1 = 1'b0;
        idle(3);
        chk("rst_busy", {31'd0, busy8}, 32'd0);
        chk("rst_done", {31'd0, done8}, 32'd0);
        chk("rst_diff", {24'd0, diff8}, 32'd0);
        chk("rst_borrow", {31'd0, borrow8}, 32'd0);
        chk("rst1_busy", {31'd0, busy1}, 32'd0);
        rst = 1'b0;
        idle(2);

        // Basic subtraction with busy window
        issue8(8'h5A, 8'h23, 8'h37, 1'b0, 1'b0);
        busy_window8("t1");
        wait_done8("t1");

        // Borrow case, then back-to-back start in the done cycle
        issue8(8'h10, 8'h20, 8'hF0, 1'b1, 1'b0);
        wait_done8("t2a");
        issue8(8'h00, 8'h00, 8'h00, 1'b0, 1'b0);
        busy_window8("t2b");
        wait_done8("t2b");
        idle(2);

        // Start while busy is ignored
        issue8(8'hFF, 8'h01, 8'hFE, 1'b0, 1'b0);
        idle(2);
        chk("t3_busy_at_restart", {31'd0, busy8}, 32'd1);
        a8 = 8'h00; b8 = 8'h00; start8 = 1'b1;
        @(negedge clk);
        start8 = 1'b0;
        wait_done8("t3");
        idle(12);

        // Reset mid-operation discards the result
        issue8(8'h01, 8'h02, 8'hFF, 1'b1, 1'b0);
        idle(2);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        q8.delete();
        last_diff8 = 8'h00;
        chk("t4_busy", {31'd0, busy8}, 32'd0);
        chk("t4_done", {31'd0, done8}, 32'd0);
        chk("t4_diff", {24'd0, diff8}, 32'd0);
        chk("t4_borrow", {31'd0, borrow8}, 32'd0);
        idle(12);
        issue8(8'h09, 8'h04, 8'h05, 1'b0, 1'b0);
        wait_done8("t4b");
        idle(2);

`ifdef SUB_SIGNED_OVF_EN
        issue8(8'h80, 8'h01, 8'h7F, 1'b0, 1'b1);
        wait_done8("ovf1");
        idle(1);
        issue8(8'h7F, 8'hFF, 8'h80, 1'b1, 1'b1);
        wait_done8("ovf2");
        idle(1);
        issue8(8'h05, 8'h03, 8'h02, 1'b0, 1'b0);
        wait_done8("ovf3");
        idle(2);
`endif

        // W=1 instance
        issue1(1'b0, 1'b1, 1'b1, 1'b1, 1'b1);
        wait_done1("w1a");
        issue1(1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
        wait_done1("w1b");
        issue1(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        wait_done1("w1c");
        idle(4);

        chk("q8_drained", q8.size(), 32'd0);
        chk("q1_drained", q1.size(), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/serial_subtractor.md
Name: serial_subtractor

Overview:
- Bit-serial W-bit subtractor; computes diff = a - b, one bit per clock, LSB first, through a single registered borrow.
- Inverse operation to the team's ripple adders; complements them in the arithmetic test set.
- The full-subtractor bit cell is built only from the team gate library (my_xor, my_and, my_or, my_nor).
- Control, shift registers and counter are behavioural RTL.

Parameters:
- W, 8, operand/result width in bits; minimum 1.
- CW, $clog2(W+1), bit-counter width; derived, not overridden.

Ports:
- clk  input  1  single system clock; all state updates on rising edge.
- rst  input  1  synchronous reset, active-high.
- start  input  1  request; sampled only when idle.
- a  input  W  minuend; captured on the accepting edge.
- b  input  W  subtrahend; captured on the accepting edge.
- busy  output  1  high while a subtraction is in progress.
- done  output  1  one-cycle pulse; diff/borrow_out valid.
- diff  output  W  result a - b mod 2^W; held until the next completion.
- borrow_out  output  1  1 when a < b, unsigned; held with diff.
- ovf  output  1  signed overflow; present only with SUB_SIGNED_OVF_EN.

Behaviour:
- Interface is fixed: one clock, clk; reset rst is synchronous and active-high.
- Reset: rst high at a rising edge forces:
  - state IDLE;
  - busy=0, done=0, diff=0, borrow_out=0, ovf=0;
  - internal shift registers, borrow flop and counter cleared.
- Reset has priority over all other inputs, including mid-operation; the partial result is discarded and done is not pulsed.
- States: IDLE and SHIFT.
- IDLE:
  - start=1 at an edge (call it E0): capture a into sa, b into sb; clear the borrow flop bin; cnt=0; busy=1; go to SHIFT.
  - start=0: stay in IDLE.
- SHIFT, at each edge Ei, i=1..W, process bit k=i-1:
  - Cell inputs x=sa[0], y=sb[0], bin.
  - d = x ^ y ^ bin.
  - bnext = (~x & y) | (~x & bin) | (y & bin).
  - sa and sb shift right by 1; d shifts into the accumulator MSB; bin <= bnext; cnt++.
- Completion at edge EW:
  - diff <= final accumulator, including bit W-1; borrow_out <= bnext.
  - done=1 for exactly one cycle; busy=0; state IDLE.
- Latency: done is high in the cycle following edge EW, which is W edges after the accepting edge E0.
- Throughput: one operation per W+1 cycles at best.
- start while busy=1 is ignored; no queuing. Operands may change freely while busy.
- start high in the done cycle is accepted at the next edge; back-to-back operation is legal.
- start held high continuously restarts immediately after each completion.
- W=1: single SHIFT edge; done follows the accepting edge by one edge.
- diff and borrow_out change only at completion or reset.
- Bit cell timing: settling time through library gate delays must be below the clock period. The bench clock period is 100 ns.

Optional Feature:
- Macro: SUB_SIGNED_OVF_EN.
- Defined:
  - Port ovf exists.
  - At completion, ovf <= (a[W-1] ^ b[W-1]) & (a[W-1] ^ diff[W-1]), using the operand sign bits captured at E0.
  - ovf is held with diff and cleared by reset.
- Undefined:
  - No ovf port and no related logic.
  - All other behaviour is identical.

Test Plan:
- Reset, then a=0x5A, b=0x23, start pulse -> done exactly 8 edges after accept; diff=0x37, borrow_out=0; busy high during the 8 cycles.
- a=0x10, b=0x20 -> diff=0xF0, borrow_out=1. Then a=0x00, b=0x00 back-to-back, start in the done cycle -> diff=0x00, borrow_out=0.
- a=0xFF, b=0x01, start; pulse start again at cycle 3 with a=0x00, b=0x00 -> second start ignored; diff=0xFE, borrow_out=0; only one done pulse.
- Start a=0x01, b=0x02; assert rst at cycle 4 -> busy=0, diff=0x00, borrow_out=0, no done. A new a=0x09, b=0x04 run afterwards -> diff=0x05.
- With SUB_SIGNED_OVF_EN:
  - a=0x80, b=0x01 -> diff=0x7F, ovf=1, borrow_out=0.
  - a=0x7F, b=0xFF -> diff=0x80, ovf=1, borrow_out=1.
  - a=0x05, b=0x03 -> ovf=0.
- W=1 instance: a=0, b=1 -> done one edge after accept; diff=1, borrow_out=1.
